eth_link_speed_detect: RTL

- Parametrised tri-mode PHY speed detector; successor to the fixed 7-bit/2-bit detector embedded in the GMII MAC wrapper.
- Measures a divided toggle from the PHY RX clock domain against the local reference clock and classifies the link as 10M, 100M or 1000M.
- Adds hysteresis (N agreeing measurements before a change), a lock indicator and a change pulse.
- Drives speed/mii_select for the GMII PHY interface and MAC.

---
 rtl/eth_link_speed_detect.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/eth_link_speed_detect.sv
// Tri-mode PHY speed detector: compares a divided RX-clock toggle against the local reference clock.
// Optional force override under `ifdef ETH_SPEED_FORCE_EN (adds force_en/force_speed ports).
module eth_link_speed_detect #(
  parameter int unsigned REF_WIDTH     = 7,
  parameter int unsigned EDGE_WIDTH    = 2,
  parameter int unsigned THRESH_100M   = 32,
  parameter int unsigned STABLE_COUNT  = 2,
  parameter logic [1:0]  DEFAULT_SPEED = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_prescale_tgl,
`ifdef ETH_SPEED_FORCE_EN
  input  logic       force_en,
  input  logic [1:0] force_speed,
`endif
  output logic [1:0] speed,
  output logic       mii_select,
  output logic       locked,
  output logic       speed_change,
  output logic       meas_done
);

  localparam int unsigned SYNC_STAGES = 3;
  localparam int unsigned AGREE_WIDTH = 4;
  localparam int unsigned SPEED_WIDTH = 2;

  localparam logic [SPEED_WIDTH-1:0] SPD_10M   = 2'b00;
  localparam logic [SPEED_WIDTH-1:0] SPD_100M  = 2'b01;
  localparam logic [SPEED_WIDTH-1:0] SPD_1000M = 2'b10;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic [REF_WIDTH-1:0]   ref_cnt;
  logic [EDGE_WIDTH-1:0]  edge_cnt;
  logic [SPEED_WIDTH-1:0] last_cand;
  logic [AGREE_WIDTH-1:0] agree_cnt;
  state_t                 state;

  logic                   edge_c;
  logic                   ref_term_c;
  logic                   edge_term_c;
  logic                   meas_end_c;
  logic [SPEED_WIDTH-1:0] cand_c;
  logic [AGREE_WIDTH-1:0] agree_upd_c;
  logic                   stable_c;

  state_t                 state_d;
  logic [SPEED_WIDTH-1:0] speed_d;
  logic                   mii_select_d;
  logic                   locked_d;
  logic                   speed_change_d;

  // Edge detect on the synchronised toggle, either polarity.
  assign edge_c      = sync[1] ^ sync[2];
  assign ref_term_c  = &ref_cnt;
  assign edge_term_c = &edge_cnt;
  assign meas_end_c  = ref_term_c | edge_term_c;

  // Edge terminal takes priority over the reference terminal.
  always_comb begin
    cand_c = SPD_10M;
    if (edge_term_c) begin
      cand_c = (ref_cnt >= REF_WIDTH'(THRESH_100M)) ? SPD_100M : SPD_1000M;
    end
  end

  // Agreement count after this measurement, saturating at STABLE_COUNT.
  always_comb begin
    agree_upd_c = AGREE_WIDTH'(1);
    if (cand_c == last_cand) begin
      if (agree_cnt >= AGREE_WIDTH'(STABLE_COUNT)) begin
        agree_upd_c = agree_cnt;
      end else begin
        agree_upd_c = agree_cnt + AGREE_WIDTH'(1);
      end
    end
  end

  assign stable_c = (agree_upd_c >= AGREE_WIDTH'(STABLE_COUNT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx_prescale_tgl};
    end
  end

  // Measurement window counters and agreement tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_cnt   <= '0;
      edge_cnt  <= '0;
      last_cand <= SPD_10M;
      agree_cnt <= '0;
    end else if (meas_end_c) begin
      ref_cnt   <= '0;
      edge_cnt  <= '0;
      last_cand <= cand_c;
      agree_cnt <= agree_upd_c;
    end else begin
      ref_cnt <= ref_cnt + REF_WIDTH'(1);
      if (edge_c) begin
        edge_cnt <= edge_cnt + EDGE_WIDTH'(1);
      end
    end
  end

  // Lock FSM; with STABLE_COUNT=1 a differing measurement relocks without leaving LOCKED.
  always_comb begin
    state_d        = state;
    speed_d        = speed;
    speed_change_d = 1'b0;
    case (state)
      ACQUIRE: begin
        if (meas_end_c && stable_c) begin
          state_d = LOCKED;
          if (cand_c != speed) begin
            speed_d        = cand_c;
            speed_change_d = 1'b1;
          end
        end
      end
      LOCKED: begin
        if (meas_end_c && (cand_c != speed)) begin
          if (stable_c) begin
            speed_d        = cand_c;
            speed_change_d = 1'b1;
          end else begin
            state_d = ACQUIRE;
          end
        end
      end
      default: state_d = ACQUIRE;
    endcase
    locked_d = (state_d == LOCKED);
`ifdef ETH_SPEED_FORCE_EN
    if (force_en) begin
      state_d        = ACQUIRE;
      speed_d        = force_speed;
      speed_change_d = (force_speed != speed);
      locked_d       = 1'b1;
    end
`endif
    mii_select_d = (speed_d == SPD_10M) || (speed_d == SPD_100M);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACQUIRE;
      speed        <= DEFAULT_SPEED;
      mii_select   <= (DEFAULT_SPEED != SPD_1000M);
      locked       <= 1'b0;
      speed_change <= 1'b0;
      meas_done    <= 1'b0;
    end else begin
      state        <= state_d;
      speed        <= speed_d;
      mii_select   <= mii_select_d;
      locked       <= locked_d;
      speed_change <= speed_change_d;
      meas_done    <= meas_end_c;
    end
  end

endmodule
